// File: rtl/avalon_pwm_leds_pkg.sv
// avalon_pwm_pkg: register map and bit positions shared by the Avalon-MM
// PWM LED driver and its tick generator.
//   Word offsets : CTRL, PRESCALE, PERIOD, STATUS, DUTY_BASE (+channel)
//   CTRL bits    : EN, INV
//   STATUS bits  : PENDING, EN
package avalon_pwm_pkg;

   localparam int unsigned REG_CTRL      = 0;
   localparam int unsigned REG_PRESCALE  = 1;
   localparam int unsigned REG_PERIOD    = 2;
   localparam int unsigned REG_STATUS    = 3;
   localparam int unsigned REG_DUTY_BASE = 4;

   localparam int unsigned CTRL_EN_BIT        = 0;
   localparam int unsigned CTRL_INV_BIT       = 1;
   localparam int unsigned STATUS_PENDING_BIT = 0;
   localparam int unsigned STATUS_EN_BIT      = 1;

endpackage

// File: rtl/avalon_pwm_leds_tick_gen.sv
// pwm_tick_gen: prescaler plus period counter for the PWM LED driver.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   en            - counting enable; low holds both counters at 0
//   prescale      - prescaler terminal value (tick every prescale+1 clocks)
//   period_act    - committed period terminal value
//   cnt           - current period count
//   wrap          - high on the clock where cnt returns to 0
module pwm_tick_gen #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned PRE_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [PRE_W-1:0] prescale,
   input  logic [CNT_W-1:0] period_act,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;

   // >= rather than == so lowering a limit mid-count cannot overrun it
   assign tick = en && (pre_cnt >= prescale);
   assign wrap = tick && (cnt >= period_act);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
         cnt     <= '0;
      end else if (!en) begin
         pre_cnt <= '0;
         cnt     <= '0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
         if (wrap)
            cnt <= '0;
         else if (tick)
            cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/avalon_pwm_leds.sv
// avalon_pwm_leds: multi-channel PWM LED driver on an Avalon-MM slave.
// Period and duty writes land in shadow registers and are committed at the
// period boundary (or continuously while disabled), so outputs never glitch.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   address             - word address
//   chipselect, write_n - slave select, active-low write strobe
//   writedata           - write data (upper bits ignored)
//   readdata            - combinational, zero-extended read data
//   out_port            - registered PWM outputs, one per channel
module avalon_pwm_leds
   import avalon_pwm_pkg::*;
#(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned PRE_W  = 16,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [NUM_CH-1:0] out_port
);

   logic              ctrl_en;
   logic              ctrl_inv;
   logic [PRE_W-1:0]  prescale;
   logic [CNT_W-1:0]  period_sh;
   logic [CNT_W-1:0]  period_act;
   logic [CNT_W-1:0]  duty_sh  [NUM_CH];
   logic [CNT_W-1:0]  duty_act [NUM_CH];
   logic              pending;

   logic              wr;
   logic              shadow_wr;
   logic              commit;
   logic [CNT_W-1:0]  cnt;
   logic              wrap;
   logic [NUM_CH-1:0] active;
   logic              unused_wdata;

   assign wr           = chipselect && !write_n;
   assign commit       = wrap || !ctrl_en;
   assign unused_wdata = ^writedata;

   always_comb begin
      shadow_wr = wr && (address == ADDR_W'(REG_PERIOD));
      for (int unsigned i = 0; i < NUM_CH; i++)
         if (wr && (address == ADDR_W'(REG_DUTY_BASE + i)))
            shadow_wr = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en   <= 1'b0;
         ctrl_inv  <= 1'b0;
         prescale  <= '0;
         period_sh <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++)
            duty_sh[i] <= '0;
      end else if (wr) begin
         if (address == ADDR_W'(REG_CTRL)) begin
            ctrl_en  <= writedata[CTRL_EN_BIT];
            ctrl_inv <= writedata[CTRL_INV_BIT];
         end
         if (address == ADDR_W'(REG_PRESCALE))
            prescale <= writedata[PRE_W-1:0];
         if (address == ADDR_W'(REG_PERIOD))
            period_sh <= writedata[CNT_W-1:0];
         for (int unsigned i = 0; i < NUM_CH; i++)
            if (address == ADDR_W'(REG_DUTY_BASE + i))
               duty_sh[i] <= writedata[CNT_W-1:0];
      end
   end

   // A commit coinciding with a shadow write copies the old shadow contents
   // (non-blocking read of the shadow), and the write keeps PENDING set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_act <= '0;
         pending    <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++)
            duty_act[i] <= '0;
      end else begin
         if (commit) begin
            period_act <= period_sh;
            for (int unsigned i = 0; i < NUM_CH; i++)
               duty_act[i] <= duty_sh[i];
         end
         if (shadow_wr)
            pending <= 1'b1;
         else if (commit)
            pending <= 1'b0;
      end
   end

   pwm_tick_gen #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
   ) u_tick_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (ctrl_en),
      .prescale   (prescale),
      .period_act (period_act),
      .cnt        (cnt),
      .wrap       (wrap)
   );

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign active[g] = (cnt < duty_act[g]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         out_port <= '0;
      else
         out_port <= ctrl_en ? (active ^ {NUM_CH{ctrl_inv}}) : {NUM_CH{ctrl_inv}};
   end

   always_comb begin
      readdata = '0;
      if (address == ADDR_W'(REG_CTRL)) begin
         readdata[CTRL_EN_BIT]  = ctrl_en;
         readdata[CTRL_INV_BIT] = ctrl_inv;
      end
      if (address == ADDR_W'(REG_PRESCALE))
         readdata[PRE_W-1:0] = prescale;
      if (address == ADDR_W'(REG_PERIOD))
         readdata[CNT_W-1:0] = period_sh;
      if (address == ADDR_W'(REG_STATUS)) begin
         readdata[STATUS_PENDING_BIT] = pending;
         readdata[STATUS_EN_BIT]      = ctrl_en;
      end
      for (int unsigned i = 0; i < NUM_CH; i++)
         if (address == ADDR_W'(REG_DUTY_BASE + i))
            readdata[CNT_W-1:0] = duty_sh[i];
   end

endmodule

// File: tb/tb_avalon_pwm_leds.sv
// Self-checking bench for avalon_pwm_leds: register table plus directed
// waveform sequences with hand-computed expected PWM patterns.
module tb_avalon_pwm_leds;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] wave [0:63];

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [16];

   avalon_pwm_leds #(
      .NUM_CH (8),
      .CNT_W  (8),
      .PRE_W  (16),
      .ADDR_W (5)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      check(name, 64'(readdata), 64'(exp));
      chipselect = 1'b0;
   endtask

   // wave[k] = out_port just after the k-th rising edge following the call
   task automatic capture(input int n);
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         wave[k] = out_port;
      end
   endtask

   function automatic logic [63:0] chan(input int ch, input int n);
      logic [63:0] r = '0;
      for (int k = 1; k <= n; k++)
         r[k-1] = wave[k][ch];
      return r;
   endfunction

   function automatic logic [63:0] fill(input int n, input logic v);
      logic [63:0] r = '0;
      for (int k = 1; k <= n; k++)
         r[k-1] = v;
      return r;
   endfunction

   initial begin
      logic [63:0] e;

      vecs[0]  = '{1'b0, 5'd0,  32'h0,        32'h0};
      vecs[1]  = '{1'b0, 5'd1,  32'h0,        32'h0};
      vecs[2]  = '{1'b0, 5'd2,  32'h0,        32'h0};
      vecs[3]  = '{1'b0, 5'd3,  32'h0,        32'h0};
      vecs[4]  = '{1'b0, 5'd4,  32'h0,        32'h0};
      vecs[5]  = '{1'b0, 5'd11, 32'h0,        32'h0};
      vecs[6]  = '{1'b0, 5'd12, 32'h0,        32'h0};
      vecs[7]  = '{1'b0, 5'd31, 32'h0,        32'h0};
      vecs[8]  = '{1'b1, 5'd0,  32'hFFFFFFFE, 32'h2};
      vecs[9]  = '{1'b1, 5'd1,  32'hABCD1234, 32'h1234};
      vecs[10] = '{1'b1, 5'd2,  32'h000001FF, 32'hFF};
      vecs[11] = '{1'b1, 5'd4,  32'h0000003C, 32'h3C};
      vecs[12] = '{1'b1, 5'd11, 32'hFFFFFF80, 32'h80};
      vecs[13] = '{1'b1, 5'd12, 32'hFFFFFFFF, 32'h0};
      vecs[14] = '{1'b1, 5'd31, 32'h00000055, 32'h0};
      vecs[15] = '{1'b1, 5'd3,  32'h000000FF, 32'h0};

      #22 reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_out_port", 64'(out_port), 64'h0);

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].wr)
            bus_write(vecs[i].addr, vecs[i].wdata);
         read_check($sformatf("reg_vec%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
      end
      check("inv_idle_out_port", 64'(out_port), 64'hFF);

      // fresh start
      #3 reset_n = 1'b0;
      #4 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // basic PWM: period 10, duties 3 / 0 / 10
      bus_write(5'd1, 32'd0);
      bus_write(5'd2, 32'd9);
      bus_write(5'd4, 32'd3);
      bus_write(5'd5, 32'd0);
      bus_write(5'd6, 32'd10);
      bus_write(5'd0, 32'h1);
      capture(40);
      e = '0;
      for (int k = 1; k <= 40; k++) e[k-1] = ((k - 1) % 10) < 3;
      check("pwm_ch0_3of10", chan(0, 40), e);
      check("pwm_ch1_duty0", chan(1, 40), fill(40, 1'b0));
      check("pwm_ch2_over_period", chan(2, 40), fill(40, 1'b1));

      // mid-period duty change, commit at next wrap
      bus_write(5'd4, 32'd7);
      read_check("status_pending_set", 5'd3, 32'h3);
      capture(20);
      e = '0;
      for (int j = 1; j <= 20; j++) begin
         int k;
         k = 41 + j;
         e[j-1] = ((k - 1) % 10) < ((k <= 50) ? 3 : 7);
      end
      check("pwm_ch0_duty_change", chan(0, 20), e);
      read_check("status_pending_clear", 5'd3, 32'h2);
      read_check("duty0_shadow_readback", 5'd4, 32'd7);

      // prescaled: PRESCALE 4, PERIOD 3, DUTY0 2
      bus_write(5'd0, 32'h0);
      bus_write(5'd1, 32'd4);
      bus_write(5'd2, 32'd3);
      bus_write(5'd4, 32'd2);
      bus_write(5'd0, 32'h1);
      capture(40);
      e = '0;
      for (int k = 1; k <= 40; k++) e[k-1] = (((k - 1) / 5) % 4) < 2;
      check("pre_ch0_10on_10off", chan(0, 40), e);
      check("pre_ch2_over_period", chan(2, 40), fill(40, 1'b1));
      check("pre_ch1_duty0", chan(1, 40), fill(40, 1'b0));

      // period_act = 0
      bus_write(5'd0, 32'h0);
      bus_write(5'd1, 32'd0);
      bus_write(5'd2, 32'd0);
      bus_write(5'd4, 32'd1);
      bus_write(5'd0, 32'h1);
      capture(10);
      check("p0_ch0_const_on", chan(0, 10), fill(10, 1'b1));
      check("p0_ch1_const_off", chan(1, 10), fill(10, 1'b0));
      read_check("p0_status", 5'd3, 32'h2);

      // inverted polarity, then disable
      bus_write(5'd0, 32'h0);
      bus_write(5'd1, 32'd4);
      bus_write(5'd2, 32'd3);
      bus_write(5'd4, 32'd2);
      bus_write(5'd0, 32'h3);
      capture(20);
      e = '0;
      for (int k = 1; k <= 20; k++) e[k-1] = !((((k - 1) / 5) % 4) < 2);
      check("inv_ch0", chan(0, 20), e);
      check("inv_ch1_duty0", chan(1, 20), fill(20, 1'b1));
      check("inv_ch2_full", chan(2, 20), fill(20, 1'b0));
      bus_write(5'd0, 32'h2);
      capture(3);
      check("disable_inactive_ones", {wave[1], wave[2], wave[3]}, 64'hFFFFFF);
      read_check("disable_status", 5'd3, 32'h0);
      bus_write(5'd0, 32'h1);
      capture(20);
      e = '0;
      for (int k = 1; k <= 20; k++) e[k-1] = (((k - 1) / 5) % 4) < 2;
      check("restart_from_zero", chan(0, 20), e);

      // shadow write on the exact wrap cycle
      bus_write(5'd0, 32'h0);
      bus_write(5'd1, 32'd0);
      bus_write(5'd2, 32'd9);
      bus_write(5'd4, 32'd3);
      bus_write(5'd0, 32'h1);
      for (int k = 1; k <= 40; k++) begin
         if (k == 5 || k == 10) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            address    = 5'd4;
            writedata  = (k == 5) ? 32'd5 : 32'd7;
         end
         @(posedge clk);
         #1;
         chipselect = 1'b0;
         write_n    = 1'b1;
         writedata  = '0;
         wave[k] = out_port;
         if (k == 5)
            read_check("wrapwr_pending_a", 5'd3, 32'h3);
         if (k == 10) begin
            read_check("wrapwr_pending_b", 5'd3, 32'h3);
            read_check("wrapwr_shadow", 5'd4, 32'd7);
         end
      end
      e = '0;
      for (int k = 1; k <= 40; k++)
         e[k-1] = ((k - 1) % 10) < ((k <= 10) ? 3 : ((k <= 20) ? 5 : 7));
      check("wrapwr_ch0", chan(0, 40), e);
      read_check("wrapwr_pending_clear", 5'd3, 32'h2);

      // asynchronous reset mid-period
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("async_reset_out", 64'(out_port), 64'h0);
      read_check("rst_ctrl", 5'd0, 32'h0);
      read_check("rst_period", 5'd2, 32'h0);
      read_check("rst_duty2", 5'd6, 32'h0);
      read_check("rst_status", 5'd3, 32'h0);
      #7 reset_n = 1'b1;
      capture(4);
      check("post_reset_idle", {wave[1], wave[2], wave[3], wave[4]}, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
